// File: rtl/xpb_table_gen.sv
// xpb_table_gen
//   Fills one XPB reduction lookup table at run time. Given B = 2^k mod N and
//   N, it emits entries j*B mod N for j = 1 .. 2^DIGIT-1 in ascending order on
//   a valid/ready write port. Each entry is built from the previous one with a
//   single add and at most one conditional subtract. This works because acc < N
//   and B < N, so sum < 2N.
//
//   Optional feature macro: XPB_GEN_ZERO_WRITE_EN
//     When it is defined, entry 0 (addr 0, data 0) is written first, so the
//     whole 2^DIGIT-deep table is covered. When it is undefined, the sink must
//     make index 0 read as zero.
//
// Ports
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   start            : request a run; sampled only in IDLE
//   base, modulus    : B and N, latched together with start
//   busy             : run in progress (ADD/RED/WR states)
//   done             : one-cycle pulse at the end of a run (normal or error)
//   err              : base >= modulus at start; held until next accepted start
//   wr_valid/wr_ready: write handshake toward table storage
//   wr_addr, wr_data : table index j and j*B mod N
module xpb_table_gen #(
  parameter int WIDTH = 1024,
  parameter int DIGIT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [DIGIT-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  typedef enum logic [2:0] {IDLE, ADD, RED, WR, FIN} state_t;

`ifdef XPB_GEN_ZERO_WRITE_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  localparam logic [DIGIT-1:0] LAST_IDX = '1;
  // With the zero entry enabled, the run opens in WR with entry 0 preloaded.
  localparam state_t FIRST_ST = ZERO_EN ? WR : ADD;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] base_r, mod_r, acc, red_val;
  logic [WIDTH:0]   sum;          // one extra bit keeps the carry of acc + B
  logic [DIGIT-1:0] idx;
  logic             bad_start, zero_ent;

  assign bad_start = (base >= modulus);

  // Entry 0 is the only WR entry with address 0. It must not advance idx, and
  // it cannot be the last entry.
  assign zero_ent = ZERO_EN && (wr_addr == '0);

  // The result is below N. The low WIDTH bits of the difference are exact.
  assign red_val = (sum >= {1'b0, mod_r}) ? (sum[WIDTH-1:0] - mod_r)
                                          : sum[WIDTH-1:0];

  assign busy = (state == ADD) || (state == RED) || (state == WR);
  assign done = (state == FIN);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = bad_start ? FIN : FIRST_ST;
      ADD:  state_nxt = RED;
      RED:  state_nxt = WR;
      WR:   if (wr_ready) state_nxt = (!zero_ent && idx == LAST_IDX) ? FIN : ADD;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r   <= '0;
      mod_r    <= '0;
      acc      <= '0;
      sum      <= '0;
      idx      <= '0;
      err      <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_r <= base;
          mod_r  <= modulus;
          acc    <= '0;
          idx    <= {{(DIGIT-1){1'b0}}, 1'b1};
          err    <= bad_start;
          if (ZERO_EN && !bad_start) begin
            wr_valid <= 1'b1;
            wr_addr  <= '0;
            wr_data  <= '0;
          end
        end
        ADD: sum <= {1'b0, acc} + {1'b0, base_r};
        RED: begin
          acc      <= red_val;
          wr_data  <= red_val;
          wr_addr  <= idx;
          wr_valid <= 1'b1;
        end
        WR: if (wr_ready) begin
          wr_valid <= 1'b0;
          if (!zero_ent && idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
module tb_xpb_table_gen;

`ifdef XPB_GEN_ZERO_WRITE_EN
  localparam int ZW = 1;
`else
  localparam int ZW = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;

  // small instance: WIDTH=16, DIGIT=3
  logic        start = 1'b0;
  logic [15:0] base = '0, modulus = '0;
  logic        busy, done, err, wr_valid;
  logic        wr_ready = 1'b1;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  // large instance: WIDTH=1024, DIGIT=5
  logic          start_b = 1'b0;
  logic [1023:0] base_b = '0, mod_b = '0;
  logic          busy_b, done_b, err_b, wv_b;
  logic          ready_b = 1'b1;
  logic [4:0]    wa_b;
  logic [1023:0] wd_b;

  xpb_table_gen #(.WIDTH(16), .DIGIT(3)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .modulus(modulus),
    .busy(busy), .done(done), .err(err), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data));

  xpb_table_gen #(.WIDTH(1024), .DIGIT(5)) u_big (
    .clk(clk), .reset(reset), .start(start_b), .base(base_b), .modulus(mod_b),
    .busy(busy_b), .done(done_b), .err(err_b), .wr_valid(wv_b),
    .wr_ready(ready_b), .wr_addr(wa_b), .wr_data(wd_b));

  int vectors = 0;
  int miscompares = 0;

  // capture of one small-instance run
  int          cap_addr[$];
  logic [15:0] cap_data[$];
  int          cap_cyc[$];
  int          done_cyc, busy_bad, unstable, stalls;
  logic        err_c1, err_done;

  // reference model: plain modular arithmetic
  function automatic logic [15:0] model_entry(input int j, input logic [15:0] b, m);
    longint p;
    p = longint'(j) * longint'(b);
    return 16'(p % longint'(m));
  endfunction

  // mode 0: ready high except the optional stall; mode 1: random ready
  task automatic run_small(input logic [15:0] b, m, input int mode,
                           input int stall_addr, input int stall_len);
    int left; logic pv, hs; logic [2:0] pa; logic [15:0] pd;
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    done_cyc = -1; busy_bad = 0; unstable = 0; stalls = 0;
    err_c1 = 1'bx; err_done = 1'bx;
    left = stall_len; pv = 1'b0; hs = 1'b0; pa = '0; pd = '0;
    @(negedge clk);
    start = 1'b1; base = b; modulus = m; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (c == 1) err_c1 = err;
      if (pv && !hs && (!wr_valid || wr_addr !== pa || wr_data !== pd)) unstable++;
      wr_ready = 1'b1;
      if (mode == 1) wr_ready = ($urandom_range(0, 99) < 65);
      if (wr_valid && int'(wr_addr) == stall_addr && left > 0) begin
        wr_ready = 1'b0;
        left--;
      end
      if (wr_valid && !wr_ready) stalls++;
      hs = wr_valid && wr_ready;
      if (hs) begin
        cap_addr.push_back(int'(wr_addr));
        cap_data.push_back(wr_data);
        cap_cyc.push_back(c);
      end
      if (done) begin
        if (busy) busy_bad++;
        err_done = err;
        done_cyc = c;
        break;
      end else if (!busy) busy_bad++;
      pv = wr_valid; pa = wr_addr; pd = wr_data;
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, err, wr_valid, wr_addr, wr_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_small: got busy=%b done=%b err=%b v=%b a=%0d d=%h, want all 0",
               busy, done, err, wr_valid, wr_addr, wr_data);
    end
    vectors++;
    if ({busy_b, done_b, err_b, wv_b, wa_b} !== '0 || wd_b !== '0) begin
      miscompares++;
      $display("FAIL reset_big: got busy=%b done=%b err=%b v=%b a=%0d, want all 0",
               busy_b, done_b, err_b, wv_b, wa_b);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] tbl [7];
    tbl = '{16'd100, 16'd200, 16'd49, 16'd149, 16'd249, 16'd98, 16'd198};
    run_small(16'h0064, 16'h00FB, 0, -1, 0);
    vectors++;
    if (cap_addr.size() != 7 + ZW) begin
      miscompares++;
      $display("FAIL directed_count: got %0d writes, want %0d", cap_addr.size(), 7 + ZW);
    end else begin
      for (int i = 0; i < 7 + ZW; i++) begin
        int j; logic [15:0] e; int ec;
        j  = i + 1 - ZW;
        e  = (j == 0) ? 16'd0 : tbl[j-1];
        ec = (j == 0) ? 1 : 3 * j + ZW;
        vectors++;
        if (cap_addr[i] != j || cap_data[i] !== e || cap_cyc[i] != ec) begin
          miscompares++;
          $display("FAIL directed_entry%0d: got (%0d,%0d)@%0d, want (%0d,%0d)@%0d",
                   i, cap_addr[i], cap_data[i], cap_cyc[i], j, e, ec);
        end
      end
    end
    vectors++;
    if (done_cyc != 22 + ZW || busy_bad != 0 || err_c1 !== 1'b0) begin
      miscompares++;
      $display("FAIL directed_done: got done@%0d busy_bad=%0d err=%b, want done@%0d 0 0",
               done_cyc, busy_bad, err_c1, 22 + ZW);
    end
  endtask

  task automatic test_backpressure();
    run_small(16'h0064, 16'h00FB, 0, 3, 5);
    vectors++;
    if (unstable != 0 || stalls != 5) begin
      miscompares++;
      $display("FAIL bp_stable: got unstable=%0d stalls=%0d, want 0 and 5", unstable, stalls);
    end
    vectors++;
    if (done_cyc != 27 + ZW) begin
      miscompares++;
      $display("FAIL bp_done: got done@%0d, want %0d", done_cyc, 27 + ZW);
    end
    vectors++;
    if (cap_addr.size() != 7 + ZW || cap_addr[2+ZW] != 3 || cap_data[2+ZW] !== 16'd49
        || cap_cyc[2+ZW] != 14 + ZW) begin
      miscompares++;
      $display("FAIL bp_entry3: got n=%0d, want entry 3 = 49 handshaking at cycle %0d",
               cap_addr.size(), 14 + ZW);
    end
  endtask

  task automatic test_error();
    run_small(16'h00FB, 16'h00FB, 0, -1, 0);
    vectors++;
    if (done_cyc != 1 || err_c1 !== 1'b1 || cap_addr.size() != 0 || busy_bad != 0) begin
      miscompares++;
      $display("FAIL error_path: got done@%0d err=%b writes=%0d busy_bad=%0d, want 1 1 0 0",
               done_cyc, err_c1, cap_addr.size(), busy_bad);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (err !== 1'b1 || wr_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL error_sticky: got err=%b v=%b busy=%b, want 1 0 0", err, wr_valid, busy);
    end
    run_small(16'h0064, 16'h00FB, 0, -1, 0);
    vectors++;
    if (err_c1 !== 1'b0 || done_cyc != 22 + ZW || cap_addr.size() != 7 + ZW) begin
      miscompares++;
      $display("FAIL error_clear: got err=%b done@%0d writes=%0d, want 0 %0d %0d",
               err_c1, done_cyc, cap_addr.size(), 22 + ZW, 7 + ZW);
    end
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    start = 1'b1; base = 16'h0064; modulus = 16'h00FB; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end  // now in cycle 8
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, err, wr_valid, wr_addr, wr_data} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got busy=%b done=%b err=%b v=%b a=%0d d=%0d, want all 0",
               busy, done, err, wr_valid, wr_addr, wr_data);
    end
    reset = 1'b0;
    run_small(16'h0064, 16'h00FB, 0, -1, 0);
    vectors++;
    if (cap_addr.size() != 7 + ZW || done_cyc != 22 + ZW) begin
      miscompares++;
      $display("FAIL midrun_rerun_count: got %0d writes done@%0d, want %0d done@%0d",
               cap_addr.size(), done_cyc, 7 + ZW, 22 + ZW);
    end else begin
      for (int i = ZW; i < 7 + ZW; i++) begin
        vectors++;
        if (cap_data[i] !== model_entry(i + 1 - ZW, 16'h0064, 16'h00FB)) begin
          miscompares++;
          $display("FAIL midrun_rerun_entry%0d: got %0d, want %0d", i, cap_data[i],
                   model_entry(i + 1 - ZW, 16'h0064, 16'h00FB));
        end
      end
    end
  endtask

  task automatic test_overflow();
    run_small(16'hFFF0, 16'hFFF1, 0, -1, 0);
    vectors++;
    if (cap_addr.size() != 7 + ZW || cap_data[1+ZW] !== 16'hFFEF) begin
      miscompares++;
      $display("FAIL overflow_entry2: got n=%0d d=%h, want n=%0d d=ffef",
               cap_addr.size(), (cap_addr.size() > 1 + ZW) ? cap_data[1+ZW] : 16'hxxxx, 7 + ZW);
    end else begin
      for (int i = ZW; i < 7 + ZW; i++) begin
        vectors++;
        if (cap_data[i] !== model_entry(i + 1 - ZW, 16'hFFF0, 16'hFFF1)) begin
          miscompares++;
          $display("FAIL overflow_entry%0d: got %h, want %h", i, cap_data[i],
                   model_entry(i + 1 - ZW, 16'hFFF0, 16'hFFF1));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      logic [15:0] m, b;
      m = 16'($urandom_range(2, 65535));
      b = 16'($urandom % 32'(m));
      run_small(b, m, 1, -1, 0);
      vectors++;
      if (cap_addr.size() != 7 + ZW || done_cyc != 22 + ZW + stalls
          || unstable != 0 || busy_bad != 0 || err_done !== 1'b0) begin
        miscompares++;
        $display("FAIL random%0d_run: b=%h m=%h got n=%0d done@%0d unst=%0d busy_bad=%0d err=%b, want n=%0d done@%0d",
                 it, b, m, cap_addr.size(), done_cyc, unstable, busy_bad, err_done,
                 7 + ZW, 22 + ZW + stalls);
      end else begin
        for (int i = 0; i < 7 + ZW; i++) begin
          int j; logic [15:0] e;
          j = i + 1 - ZW;
          e = (j == 0) ? 16'd0 : model_entry(j, b, m);
          vectors++;
          if (cap_addr[i] != j || cap_data[i] !== e) begin
            miscompares++;
            $display("FAIL random%0d_entry%0d: got (%0d,%h), want (%0d,%h)",
                     it, i, cap_addr[i], cap_data[i], j, e);
          end
        end
      end
    end
  endtask

  task automatic test_big();
    logic [1023:0] m, e;
    int n, dc;
    logic eb;
    m = '0; m[1023] = 1'b1; m[0] = 1'b1;
    n = 0; dc = -1; eb = 1'bx;
    @(negedge clk);
    start_b = 1'b1; base_b = 1024'd1; mod_b = m;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (wv_b) begin
        int j;
        j = n + 1 - ZW;
        e = '0; e[4:0] = 5'(j);
        vectors++;
        if (int'(wa_b) != j || wd_b !== e) begin
          miscompares++;
          $display("FAIL big_entry%0d: got addr=%0d data[31:0]=%0d, want %0d/%0d",
                   n, wa_b, wd_b[31:0], j, j);
        end
        n++;
      end
      if (done_b) begin
        dc = c;
        eb = err_b | busy_b;
        break;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (n != 31 + ZW || dc != 94 + ZW || eb !== 1'b0) begin
      miscompares++;
      $display("FAIL big_done: got %0d writes done@%0d err|busy=%b, want %0d done@%0d 0",
               n, dc, eb, 31 + ZW, 94 + ZW);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_error();
    test_midrun_reset();
    test_overflow();
    test_random();
    test_big();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
